// File: rtl/audio_pkg.sv
// Shared types and constants for the song sequencer and the voice datapath it feeds.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_FADE = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam logic [8:0] KICK_START_INC = 9'h1c0;
    localparam logic [3:0] VOL_SILENT     = 4'd15;

    // One attenuation step towards silence, sticking at VOL_SILENT.
    function automatic logic [3:0] vol_step(input logic [3:0] v);
        return (v == VOL_SILENT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Control inputs and strobe/envelope outputs of the song sequencer; master is the sequencer side.
interface song_sequencer_if;
    logic       run;
    logic       restart;
    logic       trig_kick;
    logic       trig_snare;
    logic       trig_pulse;
    logic [7:0] songpos;
    logic [7:0] songpos_next;
    logic       sample_stb;
    logic       tick_stb;
    logic       beat_stb;
    logic       arpidx;
    logic       kick_load;
    logic       kick_decay;
    logic       bass_load;
    logic [3:0] noise_vol;
    logic [3:0] pulse_vol;
    logic       done;

    modport master (
        input  run, restart, trig_kick, trig_snare, trig_pulse,
        output songpos, songpos_next, sample_stb, tick_stb, beat_stb, arpidx,
               kick_load, kick_decay, bass_load, noise_vol, pulse_vol, done
    );

    modport slave (
        output run, restart, trig_kick, trig_snare, trig_pulse,
        input  songpos, songpos_next, sample_stb, tick_stb, beat_stb, arpidx,
               kick_load, kick_decay, bass_load, noise_vol, pulse_vol, done
    );
endinterface

// File: rtl/seq_timebase.sv
// Sample and tick dividers; tick_en is the combinational wrap condition, strobes register it one cycle later.
// run=0 holds both counters; restart clears them and masks tick_en in the same cycle.
module seq_timebase #(
    parameter int SAMPLE_DIV_BITS = 10,
    parameter int TICK_DIV_BITS   = 8
) (
    input  logic clk48,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic tick_en,
    output logic sample_stb,
    output logic tick_stb
);

    logic [SAMPLE_DIV_BITS-1:0] sample_cnt;
    logic [TICK_DIV_BITS-1:0]   tick_cnt;
    logic                       sample_en;

    assign sample_en = run && !restart && (&sample_cnt);
    assign tick_en   = sample_en && (&tick_cnt);

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            tick_cnt   <= '0;
            sample_stb <= 1'b0;
            tick_stb   <= 1'b0;
        end else if (restart) begin
            sample_cnt <= '0;
            tick_cnt   <= '0;
            sample_stb <= 1'b0;
            tick_stb   <= 1'b0;
        end else begin
            if (run) sample_cnt <= sample_cnt + 1'b1;
            if (sample_en) tick_cnt <= tick_cnt + 1'b1;
            sample_stb <= sample_en;
            tick_stb   <= tick_en;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Swing beat scheduler, kick/bass strobes and noise/pulse envelopes; all strobes register on the divider wrap edge.
// run=0 freezes all state; SONG_LOOP_EN loops the song forever, otherwise it ends via FADE into DONE.
module song_sequencer
    import audio_pkg::*;
#(
    parameter int SAMPLE_DIV_BITS = 10,
    parameter int TICK_DIV_BITS   = 8,
    parameter int LONG_TICKS      = 24,
    parameter int SHORT_TICKS     = 14,
    parameter int KICK_FRAMES     = 7
) (
    input  logic             clk48,
    input  logic             rst,
    song_sequencer_if.master bus
);

    localparam int CW = $clog2((LONG_TICKS > SHORT_TICKS) ? LONG_TICKS : SHORT_TICKS);
    localparam int KW = $clog2(KICK_FRAMES + 1);
    localparam logic [CW-1:0] LONG_RL  = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] SHORT_RL = CW'(SHORT_TICKS - 1);
    localparam logic [KW-1:0] KICK_RL  = KW'(KICK_FRAMES);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] countdown, beat_tick, tick_idx_nxt;
    logic [KW-1:0] kick_cnt;
    logic [7:0]    songpos, songpos_nxt;
    logic [3:0]    noise_vol, pulse_vol;
    logic          played, beat_stb, kick_load, kick_decay, bass_load;
    logic          sample_stb, tick_stb, tick_now, beat_now, song_end, trig_ok;
    logic          done_nxt, run_eff, in_play, done;

    assign songpos_nxt = songpos + 8'd1;
    // Freezing on the edge that enters DONE keeps that edge from emitting strobes.
    assign done_nxt = (state == ST_DONE) ||
                      ((state == ST_FADE) && (noise_vol == VOL_SILENT) && (pulse_vol == VOL_SILENT));
    assign run_eff  = bus.run && !done_nxt;

    seq_timebase #(
        .SAMPLE_DIV_BITS(SAMPLE_DIV_BITS),
        .TICK_DIV_BITS  (TICK_DIV_BITS)
    ) u_timebase (
        .clk48     (clk48),
        .rst       (rst),
        .run       (run_eff),
        .restart   (bus.restart),
        .tick_en   (tick_now),
        .sample_stb(sample_stb),
        .tick_stb  (tick_stb)
    );

    assign beat_now = tick_now && (countdown == '0);
`ifdef SONG_LOOP_EN
    assign song_end = 1'b0;
`else
    // The first beat also steps 8'hFF to 0; only a wrap after real play ends the song.
    assign song_end = beat_now && played && (songpos == 8'hFF);
`endif
    assign trig_ok      = beat_now && in_play && !song_end;
    assign tick_idx_nxt = beat_tick + 1'b1;

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state <= ST_PLAY;
        end else if (bus.restart) begin
            state <= ST_PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PLAY: if (song_end) state_nxt = ST_FADE;
            ST_FADE: if ((noise_vol == VOL_SILENT) && (pulse_vol == VOL_SILENT)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_PLAY;
        endcase
    end

    always_comb begin
        in_play = (state == ST_PLAY);
        done    = 1'b0;
`ifndef SONG_LOOP_EN
        done    = (state == ST_DONE);
`endif
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            songpos    <= 8'hFF;
            countdown  <= '0;
            beat_tick  <= '0;
            kick_cnt   <= '0;
            noise_vol  <= VOL_SILENT;
            pulse_vol  <= VOL_SILENT;
            played     <= 1'b0;
            beat_stb   <= 1'b0;
            kick_load  <= 1'b0;
            kick_decay <= 1'b0;
            bass_load  <= 1'b0;
        end else if (bus.restart) begin
            songpos    <= 8'hFF;
            countdown  <= '0;
            beat_tick  <= '0;
            kick_cnt   <= '0;
            noise_vol  <= VOL_SILENT;
            pulse_vol  <= VOL_SILENT;
            played     <= 1'b0;
            beat_stb   <= 1'b0;
            kick_load  <= 1'b0;
            kick_decay <= 1'b0;
            bass_load  <= 1'b0;
        end else begin
            beat_stb   <= beat_now;
            kick_load  <= trig_ok && bus.trig_kick;
            kick_decay <= tick_now && !beat_now && (kick_cnt != '0);
            bass_load  <= tick_now && !beat_now && (kick_cnt == '0) && in_play;
            if (beat_now) begin
                songpos   <= songpos_nxt;
                countdown <= songpos_nxt[0] ? SHORT_RL : LONG_RL;
                beat_tick <= '0;
                played    <= 1'b1;
                if (trig_ok && bus.trig_kick)  kick_cnt  <= KICK_RL;
                if (trig_ok && bus.trig_snare) noise_vol <= 4'd0;
                if (trig_ok && bus.trig_pulse) pulse_vol <= 4'd0;
            end else if (tick_now) begin
                countdown <= countdown - 1'b1;
                beat_tick <= tick_idx_nxt;
                if (kick_cnt != '0) kick_cnt <= kick_cnt - 1'b1;
                if (tick_idx_nxt[1:0] == 2'd3) noise_vol <= vol_step(noise_vol);
                if (tick_idx_nxt[2:0] == 3'd7) pulse_vol <= vol_step(pulse_vol);
            end
        end
    end

    assign bus.songpos      = songpos;
    assign bus.songpos_next = songpos_nxt;
    assign bus.sample_stb   = sample_stb;
    assign bus.tick_stb     = tick_stb;
    assign bus.beat_stb     = beat_stb;
    assign bus.arpidx       = beat_tick[2];
    assign bus.kick_load    = kick_load;
    assign bus.kick_decay   = kick_decay;
    assign bus.bass_load    = bass_load;
    assign bus.noise_vol    = noise_vol;
    assign bus.pulse_vol    = pulse_vol;
    assign bus.done         = done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with shortened dividers (4 cycles/sample, 2 samples/tick): per-cycle model compare plus directed literal checks.
module tb_song_sequencer;

    localparam int SDB   = 2;
    localparam int TDB   = 1;
    localparam int SPS   = 4;   // cycles per sample
    localparam int CPT   = 8;   // cycles per tick
    localparam int LONG  = 24;
    localparam int SHORT = 14;
    localparam int KICKF = 7;
`ifdef SONG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk48 = 1'b0;
    logic rst;
    always #5 clk48 = ~clk48;

    song_sequencer_if sif();

    song_sequencer #(
        .SAMPLE_DIV_BITS(SDB),
        .TICK_DIV_BITS  (TDB),
        .LONG_TICKS     (LONG),
        .SHORT_TICKS    (SHORT),
        .KICK_FRAMES    (KICKF)
    ) dut (
        .clk48(clk48),
        .rst  (rst),
        .bus  (sif)
    );

    // Upstream trigger tables, looked up by songpos_next.
    bit kick_tab[256];
    bit snare_tab[256];
    bit pulse_tab[256];
    assign sif.trig_kick  = kick_tab[sif.songpos_next];
    assign sif.trig_snare = snare_tab[sif.songpos_next];
    assign sif.trig_pulse = pulse_tab[sif.songpos_next];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk48);
        #3;
    endtask

    always @(posedge clk48) begin
        if (rst || sif.restart) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Behavioural model: absolute running-cycle count gives sample/tick times,
    // beats are scheduled by absolute tick number, envelopes follow the in-beat index.
    int m_cyc, m_next_beat, m_sp, m_noise, m_pulse, m_kick, m_idx, m_state, m_t;
    bit m_played, m_go_done, m_wrap, m_ok;
    bit e_sample, e_tick, e_beat, e_kload, e_kdec, e_bass;

    always @(posedge clk48) begin
        if (rst || sif.restart) begin
            m_cyc = 0; m_next_beat = 0; m_sp = 255; m_noise = 15; m_pulse = 15;
            m_kick = 0; m_idx = 0; m_state = 0; m_played = 1'b0;
            e_sample = 0; e_tick = 0; e_beat = 0; e_kload = 0; e_kdec = 0; e_bass = 0;
        end else begin
            m_go_done = (m_state == 2) || (m_state == 1 && m_noise == 15 && m_pulse == 15);
            e_sample = 0; e_tick = 0; e_beat = 0; e_kload = 0; e_kdec = 0; e_bass = 0;
            if (sif.run && !m_go_done) begin
                m_cyc++;
                e_sample = (m_cyc % SPS) == 0;
                if ((m_cyc % CPT) == 0) begin
                    m_t = m_cyc / CPT - 1;
                    e_tick = 1;
                    if (m_t == m_next_beat) begin
                        e_beat = 1;
                        m_wrap = m_played && (m_sp == 255);
                        m_sp = (m_sp + 1) % 256;
                        m_played = 1'b1;
                        m_next_beat = m_t + (((m_sp % 2) == 0) ? LONG : SHORT);
                        m_idx = 0;
                        m_ok = (m_state == 0) && !(m_wrap && !LOOP);
                        if (m_ok && kick_tab[m_sp]) begin e_kload = 1; m_kick = KICKF; end
                        if (m_ok && snare_tab[m_sp]) m_noise = 0;
                        if (m_ok && pulse_tab[m_sp]) m_pulse = 0;
                        if (m_wrap && !LOOP && m_state == 0) m_state = 1;
                    end else begin
                        m_idx++;
                        if (m_kick > 0) begin e_kdec = 1; m_kick--; end
                        else if (m_state == 0) e_bass = 1;
                        if ((m_idx % 4) == 3 && m_noise < 15) m_noise++;
                        if ((m_idx % 8) == 7 && m_pulse < 15) m_pulse++;
                    end
                end
            end
            if (m_go_done) m_state = 2;
        end
    end

    always @(posedge clk48) begin
        #2;
        if (chk_on) begin
            chk("sample_stb",   sif.sample_stb,   e_sample);
            chk("tick_stb",     sif.tick_stb,     e_tick);
            chk("beat_stb",     sif.beat_stb,     e_beat);
            chk("kick_load",    sif.kick_load,    e_kload);
            chk("kick_decay",   sif.kick_decay,   e_kdec);
            chk("bass_load",    sif.bass_load,    e_bass);
            chk("arpidx",       sif.arpidx,       (m_idx >> 2) & 1);
            chk("songpos",      sif.songpos,      m_sp);
            chk("songpos_next", sif.songpos_next, (m_sp + 1) % 256);
            chk("noise_vol",    sif.noise_vol,    m_noise);
            chk("pulse_vol",    sif.pulse_vol,    m_pulse);
            chk("done",         sif.done,         (m_state == 2) ? 1 : 0);
        end
    end

    int first_s, first_t, kl_c, n_dec, first_b, first_n, first_p;
    int beat_c[$];
    int beat_p[$];
    int exp_bc[5];
    int n_ps, b_c, b_p, wrap_c, wrap_kl, done_c, n_q;
    bit seen255;

    initial begin
        exp_bc = '{8, 200, 312, 504, 616};
        rst = 1'b1; sif.run = 1'b0; sif.restart = 1'b0;
        repeat (3) step();
        chk_on = 1'b1;
        chk("rst_songpos", sif.songpos, 255);
        chk("rst_noise",   sif.noise_vol, 15);
        chk("rst_pulse",   sif.pulse_vol, 15);
        chk("rst_done",    sif.done, 0);

        // Timebase, swing, kick sequence and envelopes from a trigger on the first beat.
        kick_tab[0] = 1; snare_tab[0] = 1; pulse_tab[0] = 1;
        rst = 1'b0; sif.run = 1'b1;
        first_s = -1; first_t = -1; kl_c = -1; n_dec = 0; first_b = -1; first_n = -1; first_p = -1;
        for (int i = 0; i < 1300; i++) begin
            step();
            if (sif.sample_stb && first_s < 0) first_s = cyc;
            if (sif.tick_stb && first_t < 0) first_t = cyc;
            if (sif.beat_stb) begin beat_c.push_back(cyc); beat_p.push_back(int'(sif.songpos)); end
            if (sif.kick_load && kl_c < 0) kl_c = cyc;
            if (sif.kick_decay) n_dec++;
            if (sif.bass_load && first_b < 0) first_b = cyc;
            if (cyc > 8 && sif.noise_vol == 4'd15 && first_n < 0) first_n = cyc;
            if (cyc > 8 && sif.pulse_vol == 4'd15 && first_p < 0) first_p = cyc;
        end
        chk("first_sample_cyc", first_s, 4);
        chk("first_tick_cyc", first_t, 8);
        chk("beat_count_ge5", (beat_c.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < beat_c.size(); i++) begin
            chk($sformatf("beat%0d_cyc", i), beat_c[i], exp_bc[i]);
            chk($sformatf("beat%0d_songpos", i), beat_p[i], i);
        end
        chk("kick_load_cyc", kl_c, 8);
        chk("kick_decay_count", n_dec, 7);
        chk("first_bass_cyc", first_b, 72);
        chk("noise_silent_cyc", first_n, 496);
        chk("pulse_silent_cyc", first_p, 1104);

        // Asynchronous reset mid-play, then a 5000-cycle pause mid-tick.
        rst = 1'b1;
        #1;
        chk("async_rst_songpos", sif.songpos, 255);
        chk("async_rst_noise", sif.noise_vol, 15);
        step();
        rst = 1'b0;
        for (int i = 0; i < 200 && cyc < 99; i++) step();
        chk("pause_start_cyc", cyc, 99);
        sif.run = 1'b0;
        n_ps = 0;
        repeat (5000) begin
            step();
            n_ps += int'(sif.sample_stb) + int'(sif.tick_stb) + int'(sif.beat_stb);
        end
        chk("pause_strobes", n_ps, 0);
        chk("pause_songpos", sif.songpos, 0);
        sif.run = 1'b1;
        b_c = -1; b_p = -1;
        for (int i = 0; i < 300 && b_c < 0; i++) begin
            step();
            if (sif.beat_stb) begin b_c = cyc; b_p = int'(sif.songpos); end
        end
        chk("resume_beat_cyc", b_c, 5200);
        chk("resume_beat_songpos", b_p, 1);
        for (int i = 0; i < 200 && cyc < 5311; i++) step();
        chk("restart_setup_cyc", cyc, 5311);
        sif.restart = 1'b1;
        step();
        sif.restart = 1'b0;
        chk("restart_beat", sif.beat_stb, 0);
        chk("restart_tick", sif.tick_stb, 0);
        chk("restart_songpos", sif.songpos, 255);

        // Whole song: wrap behaviour and end-of-song fade.
        for (int i = 0; i < 256; i++) begin kick_tab[i] = 0; snare_tab[i] = 0; pulse_tab[i] = 0; end
        kick_tab[0] = 1; snare_tab[255] = 1; pulse_tab[255] = 1;
        seen255 = 1'b0; wrap_c = -1; wrap_kl = -1; done_c = -1;
        for (int i = 0; i < 45000 && ((LOOP && wrap_c < 0) || (!LOOP && done_c < 0)); i++) begin
            step();
            if (sif.beat_stb && sif.songpos == 8'd255) seen255 = 1'b1;
            if (sif.beat_stb && sif.songpos == 8'd0 && seen255 && wrap_c < 0) begin
                wrap_c = cyc; wrap_kl = int'(sif.kick_load);
            end
            if (sif.done && done_c < 0) done_c = cyc;
        end
        chk("wrap_cyc", wrap_c, 38920);
        if (LOOP) begin
            chk("loop_wrap_kick", wrap_kl, 1);
            n_q = 0;
            repeat (300) begin step(); n_q += int'(sif.done); end
            chk("loop_done_low", n_q, 0);
        end else begin
            chk("end_wrap_kick_ignored", wrap_kl, 0);
            chk("done_cyc", done_c, 39953);
            n_q = 0;
            repeat (64) begin
                step();
                n_q += int'(sif.sample_stb) + int'(sif.tick_stb) + int'(sif.beat_stb) + int'(sif.bass_load);
            end
            chk("done_strobes", n_q, 0);
            chk("done_held", sif.done, 1);
            sif.restart = 1'b1;
            step();
            sif.restart = 1'b0;
            chk("restart_from_done", sif.done, 0);
            chk("restart_from_done_songpos", sif.songpos, 255);
        end
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
